// File: rtl/fft8_sched_pkg.sv
// Shared types and constants for the fft8 frame scheduler.
// Optional perf counters in the top are enabled with FFT_SCHED_PERF_EN.
package fft8_sched_pkg;

  localparam int FRAME_LEN = 8;
  localparam int SAMPLE_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    UNLOAD = 3'd4
  } state_t;

  // Next requester index after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fft8_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last grant.
module rr_arbiter
  import fft8_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  int   cand;
  logic found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = int'(last_grant);
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_next(cand, NUM_REQ);
      if (!found && req[SEL_W'(cand)]) begin
        found                    = 1'b1;
        grant_oh[SEL_W'(cand)]   = 1'b1;
        grant_idx                = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fft8_frame_scheduler.sv
// Time-shares one 8-point FFT core between NUM_REQ sample streams.
// Define FFT_SCHED_PERF_EN to add the perf_frames / perf_busy counters.
module fft8_frame_scheduler
  import fft8_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       s_valid,
  output logic [NUM_REQ-1:0]       s_ready,
  input  logic [NUM_REQ*16-1:0]    s_real,
  input  logic [NUM_REQ*16-1:0]    s_imag,
  output logic                     core_start,
  output logic [127:0]             core_in_real,
  output logic [127:0]             core_in_imag,
  input  logic [127:0]             core_out_real,
  input  logic [127:0]             core_out_imag,
  input  logic                     core_done,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [15:0]              m_real,
  output logic [15:0]              m_imag,
  output logic                     m_last,
  output logic [ID_W-1:0]          m_id,
  output logic                     busy,
`ifdef FFT_SCHED_PERF_EN
  output logic [31:0]              perf_frames,
  output logic [31:0]              perf_busy,
`endif
  output logic                     err_timeout,
  output logic [2:0]               dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  // Both stream interfaces transfer on a rising clk edge where valid and
  // ready are both high; ready never depends on valid in this block.

  state_t                state, state_nxt;
  logic [ID_W-1:0]       grant_q, rr_q;
  logic [2:0]            cnt_q, ocnt_q;
  logic [WD_W-1:0]       wd_q;
  logic                  err_q;
  logic [SAMPLE_W-1:0]   in_r [FRAME_LEN];
  logic [SAMPLE_W-1:0]   in_i [FRAME_LEN];
  logic [SAMPLE_W-1:0]   ob_r [FRAME_LEN];
  logic [SAMPLE_W-1:0]   ob_i [FRAME_LEN];

  logic [NUM_REQ-1:0]    arb_oh;
  logic [ID_W-1:0]       arb_idx;
  logic                  sel_valid;
  logic [SAMPLE_W-1:0]   sel_real, sel_imag;
  logic                  load_xfer, m_xfer, wd_expired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (s_valid),
    .last_grant (rr_q),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx)
  );

  // Only the granted requester is routed and only it sees ready in LOAD.
  always_comb begin
    sel_valid = 1'b0;
    sel_real  = '0;
    sel_imag  = '0;
    s_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid  = s_valid[i];
        sel_real   = s_real[i*SAMPLE_W +: SAMPLE_W];
        sel_imag   = s_imag[i*SAMPLE_W +: SAMPLE_W];
        s_ready[i] = (state == LOAD);
      end
    end
  end

  assign load_xfer  = (state == LOAD) && sel_valid;
  assign m_xfer     = (state == UNLOAD) && m_ready;
  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:   if (|arb_oh) state_nxt = LOAD;
      LOAD:   if (load_xfer && cnt_q == 3'(FRAME_LEN - 1)) state_nxt = START;
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done)       state_nxt = UNLOAD;
        else if (wd_expired) state_nxt = IDLE;
      end
      UNLOAD: begin
        m_valid = 1'b1;
        m_last  = (ocnt_q == 3'(FRAME_LEN - 1));
        if (m_ready && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_q    <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      ocnt_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < FRAME_LEN; k++) begin
        in_r[k] <= '0;
        in_i[k] <= '0;
        ob_r[k] <= '0;
        ob_i[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|arb_oh) begin
            grant_q <= arb_idx;
            cnt_q   <= '0;
          end
        end
        LOAD: begin
          if (load_xfer) begin
            in_r[cnt_q] <= sel_real;
            in_i[cnt_q] <= sel_imag;
            cnt_q       <= cnt_q + 3'd1;
          end
        end
        START: begin
          rr_q <= grant_q;
          wd_q <= '0;
        end
        WAIT: begin
          if (core_done) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
              ob_r[k] <= core_out_real[k*SAMPLE_W +: SAMPLE_W];
              ob_i[k] <= core_out_imag[k*SAMPLE_W +: SAMPLE_W];
            end
            ocnt_q <= '0;
          end else if (wd_expired) begin
            err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        UNLOAD: if (m_xfer) ocnt_q <= ocnt_q + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    core_in_real = '0;
    core_in_imag = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      core_in_real[k*SAMPLE_W +: SAMPLE_W] = in_r[k];
      core_in_imag[k*SAMPLE_W +: SAMPLE_W] = in_i[k];
    end
  end

  assign m_real      = ob_r[ocnt_q];
  assign m_imag      = ob_i[ocnt_q];
  assign m_id        = grant_q;
  assign err_timeout = err_q;
  assign dbg_state   = state;

`ifdef FFT_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_frames <= '0;
      perf_busy   <= '0;
    end else begin
      if (busy)            perf_busy   <= perf_busy + 32'd1;
      if (m_xfer && m_last) perf_frames <= perf_frames + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft8_frame_scheduler.sv
// Directed/randomized bench for fft8_frame_scheduler with a behavioural core
// and a frame-level reference model (scoreboard queue of expected outputs).
module tb_fft8_frame_scheduler;

  localparam int N   = 2;
  localparam int IDW = 2;
  localparam int TO  = 24;
  localparam int W   = IDW + 1 + 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    s_valid, s_ready;
  logic [N*16-1:0] s_real, s_imag;
  logic            core_start, core_done;
  logic [127:0]    core_in_real, core_in_imag, core_out_real, core_out_imag;
  logic            m_valid, m_ready, m_last, busy, err_timeout;
  logic [15:0]     m_real, m_imag;
  logic [IDW-1:0]  m_id;
  logic [2:0]      dbg_state;
`ifdef FFT_SCHED_PERF_EN
  logic [31:0]     perf_frames, perf_busy;
`endif

  fft8_frame_scheduler #(
    .NUM_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .core_start(core_start), .core_in_real(core_in_real), .core_in_imag(core_in_imag),
    .core_out_real(core_out_real), .core_out_imag(core_out_imag), .core_done(core_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_last(m_last), .m_id(m_id), .busy(busy),
`ifdef FFT_SCHED_PERF_EN
    .perf_frames(perf_frames), .perf_busy(perf_busy),
`endif
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0]  q0[$], q1[$];
  logic [W-1:0] exp_q[$];
  int           id_log[$];
  logic [31:0]  load_buf[8];
  int           load_cnt, gr_model, rr_model;
  int           starts, frames_done, mv_cycles, rdy_mode, pat_idx;
  logic [1:0]   src_en;
  logic [3:0]   rdy_pat;
  logic [127:0] fr_real, fr_imag;
  logic         prev_start, prev_stall, hang;
  logic [W-1:0] prev_m;
  int           core_lat, lat_cnt;
  logic [31:0]  busy_acc, frames_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bench-defined core: reverses sample order, XORs real, offsets imag.
  function automatic logic [127:0] core_fn(input logic [127:0] r, input logic [127:0] i,
                                           input bit want_real);
    logic [127:0] res;
    res = '0;
    for (int k = 0; k < 8; k++)
      res[k*16 +: 16] = want_real ? (r[(7-k)*16 +: 16] ^ 16'h5A5A) : (i[(7-k)*16 +: 16] + 16'd3);
    return res;
  endfunction

  function automatic int arb_pick(input logic [N-1:0] v, input int rr);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      core_done     <= 1'b0;
      lat_cnt       <= 0;
      core_out_real <= '0;
      core_out_imag <= '0;
    end else if (core_start) begin
      core_out_real <= core_fn(core_in_real, core_in_imag, 1'b1);
      core_out_imag <= core_fn(core_in_real, core_in_imag, 1'b0);
      core_done     <= 1'b0;
      lat_cnt       <= core_lat;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && !hang) core_done <= 1'b1;
    end
  end

  task automatic take(input logic [31:0] smp, input int id);
    logic [127:0] er, ei;
    load_buf[load_cnt] = smp;
    load_cnt++;
    if (load_cnt == 8) begin
      for (int k = 0; k < 8; k++) begin
        fr_real[k*16 +: 16] = load_buf[k][31:16];
        fr_imag[k*16 +: 16] = load_buf[k][15:0];
      end
      er = core_fn(fr_real, fr_imag, 1'b1);
      ei = core_fn(fr_real, fr_imag, 1'b0);
      if (!hang)
        for (int k = 0; k < 8; k++)
          exp_q.push_back({IDW'(id), (k == 7), er[k*16 +: 16], ei[k*16 +: 16]});
      load_cnt = 0;
    end
  endtask

  task automatic step();
    logic [W-1:0]  cur_m, e;
    logic [31:0]   h0, h1;
    @(negedge clk);
    cur_m = {m_id, m_last, m_real, m_imag};
    chk("sready_onehot0", 128'(int'($onehot0(s_ready))), 128'd1);
    if (s_ready != '0) chk("sready_grant", 128'(s_ready), 128'(1) << gr_model);
    if (core_start) begin
      starts++;
      chk("start_pulse", 128'(prev_start), 128'd0);
      chk("core_in_real", core_in_real, fr_real);
      chk("core_in_imag", core_in_imag, fr_imag);
      rr_model = gr_model;
    end else if (busy && s_ready == '0 && !m_valid) begin
      chk("core_in_hold", core_in_real, fr_real);
    end
    if (prev_stall) chk("m_hold", 128'(cur_m), 128'(prev_m));
    if (m_valid) mv_cycles++;
`ifdef FFT_SCHED_PERF_EN
    chk("perf_busy", 128'(perf_busy), 128'(busy_acc));
    chk("perf_frames", 128'(perf_frames), 128'(frames_acc));
`endif
    h0 = (q0.size() != 0) ? q0[0] : 32'h0;
    h1 = (q1.size() != 0) ? q1[0] : 32'h0;
    s_valid[0] = src_en[0] && (q0.size() != 0);
    s_valid[1] = src_en[1] && (q1.size() != 0);
    s_real = {h1[31:16], h0[31:16]};
    s_imag = {h1[15:0], h0[15:0]};
    m_ready = (rdy_mode == 0) ? 1'b1 : rdy_pat[pat_idx % 4];
    if (m_valid) pat_idx++;
    if (!busy && s_valid != '0) gr_model = arb_pick(s_valid, rr_model);
    if (s_valid[0] && s_ready[0]) take(q0.pop_front(), 0);
    if (s_valid[1] && s_ready[1]) take(q1.pop_front(), 1);
    if (m_valid && m_ready) begin
      chk("out_expected", 128'(int'(exp_q.size() != 0)), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_sample", 128'(cur_m), 128'(e));
      end
      if (m_last) begin
        frames_done++;
        frames_acc++;
        id_log.push_back(int'(m_id));
      end
    end
    busy_acc   += 32'(busy);
    prev_start = core_start;
    prev_stall = m_valid && !m_ready;
    prev_m     = cur_m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = '0;
    m_ready = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 128'(s_ready), 128'd0);
    chk("rst_core_start", 128'(core_start), 128'd0);
    chk("rst_m_valid", 128'(m_valid), 128'd0);
    chk("rst_m_last", 128'(m_last), 128'd0);
    chk("rst_m_id", 128'(m_id), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_err", 128'(err_timeout), 128'd0);
    chk("rst_core_in_real", core_in_real, 128'd0);
    chk("rst_core_in_imag", core_in_imag, 128'd0);
`ifdef FFT_SCHED_PERF_EN
    chk("rst_perf_frames", 128'(perf_frames), 128'd0);
    chk("rst_perf_busy", 128'(perf_busy), 128'd0);
`endif
    rst_n = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete();
    load_cnt = 0; rr_model = N - 1; gr_model = 0;
    prev_start = 1'b0; prev_stall = 1'b0; prev_m = '0;
    busy_acc = '0; frames_acc = '0; fr_real = '0; fr_imag = '0;
    starts = 0; frames_done = 0;
  endtask

  task automatic push_rand(input int r);
    for (int k = 0; k < 8; k++) begin
      if (r == 0) q0.push_back($urandom());
      else        q1.push_back($urandom());
    end
  endtask

  task automatic run_frames(input string tag, input int target, input int budget);
    int c;
    c = 0;
    while (frames_done < target && c < budget) begin
      step();
      c++;
    end
    chk(tag, 128'(frames_done), 128'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int exp_ids[4];
    int wcnt, mv0, c;
    s_valid = '0; s_real = '0; s_imag = '0; m_ready = 1'b0;
    src_en = '0; rdy_mode = 0; pat_idx = 0; rdy_pat = 4'b1001;
    hang = 1'b0; core_lat = 5; mv_cycles = 0;
    exp_ids = '{0, 1, 0, 1};

    // 1: single frame, ramp data, latency 5
    do_reset();
    src_en = 2'b01;
    for (int k = 0; k < 8; k++) q0.push_back({16'(k + 1), 16'h0000});
    run_frames("t1_frames", 1, 200);
    chk("t1_starts", 128'(starts), 128'd1);
    step(); step();
    chk("t1_busy_idle", 128'(busy), 128'd0);
    chk("t1_exp_empty", 128'(exp_q.size()), 128'd0);

    // 2: both requesters always valid for four frames
    do_reset();
    id_log.delete();
    core_lat = $urandom_range(1, 8);
    src_en = 2'b11;
    push_rand(0); push_rand(0); push_rand(1); push_rand(1);
    run_frames("t2_frames", 4, 600);
    for (int k = 0; k < 4; k++)
      chk("t2_grant_order", 128'((k < id_log.size()) ? id_log[k] : -1), 128'(exp_ids[k]));
    chk("t2_starts", 128'(starts), 128'd4);

    // 3: back-pressure 1-0-0-1 during unload
    frames_done = 0;
    core_lat = $urandom_range(1, 8);
    rdy_mode = 1; pat_idx = 0;
    src_en = 2'b10;
    push_rand(1);
    run_frames("t3_frames", 1, 300);
    rdy_mode = 0;
    chk("t3_exp_empty", 128'(exp_q.size()), 128'd0);

    // 4: hung core, then a normal frame from requester 1
    hang = 1'b1; starts = 0; frames_done = 0; mv0 = mv_cycles;
    src_en = 2'b01;
    push_rand(0);
    c = 0;
    while (starts < 1 && c < 100) begin step(); c++; end
    chk("t4_started", 128'(starts), 128'd1);
    wcnt = 0; c = 0;
    while (!err_timeout && c < TO + 20) begin
      step();
      c++;
      if (busy && !err_timeout) wcnt++;
    end
    chk("t4_wait_cycles", 128'(wcnt), 128'(TO));
    chk("t4_err", 128'(err_timeout), 128'd1);
    chk("t4_busy_idle", 128'(busy), 128'd0);
    chk("t4_no_output", 128'(mv_cycles - mv0), 128'd0);
    hang = 1'b0;
    src_en = 2'b10;
    push_rand(1);
    run_frames("t4_recover_frames", 1, 300);
    chk("t4_err_sticky", 128'(err_timeout), 128'd1);
    chk("t4_exp_empty", 128'(exp_q.size()), 128'd0);

    // 5: reset while loading sample 4
    frames_done = 0;
    src_en = 2'b01;
    push_rand(0);
    c = 0;
    while (load_cnt != 4 && c < 50) begin step(); c++; end
    chk("t5_loaded4", 128'(load_cnt), 128'd4);
    do_reset();
    src_en = 2'b01;
    push_rand(0);
    run_frames("t5_frames", 1, 300);
    chk("t5_starts", 128'(starts), 128'd1);
    chk("t5_exp_empty", 128'(exp_q.size()), 128'd0);

`ifdef FFT_SCHED_PERF_EN
    // 6: perf counters over three frames
    do_reset();
    core_lat = $urandom_range(1, 8);
    src_en = 2'b11;
    for (int f = 0; f < 3; f++) push_rand(int'($urandom_range(0, 1)));
    run_frames("t6_frames", 3, 600);
    step();
    chk("t6_perf_frames", 128'(perf_frames), 128'd3);
    chk("t6_perf_busy", 128'(perf_busy), 128'(busy_acc));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft8_frame_scheduler.md
Name: fft8_frame_scheduler

Overview:
Shares one fft_8_sol5_gen2 core between NUM_REQ sample-stream requesters. It collects an 8-sample frame from the granted requester and pulses the core's start. It then waits for done, captures the 8 outputs and streams them out tagged with the requester ID. Round-robin arbitration between requesters; a watchdog recovers from a hung core.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ID_W, 2, width of requester ID (must satisfy 2**ID_W >= NUM_REQ)
TIMEOUT_CYCLES, 64, max cycles to wait for core_done before abort

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
s_valid  in  NUM_REQ  per-requester sample valid
s_ready  out  NUM_REQ  per-requester sample accept
s_real  in  NUM_REQ*16  per-requester sample real, requester i at [16i+15:16i]
s_imag  in  NUM_REQ*16  per-requester sample imag, same packing
core_start  out  1  one-cycle start pulse to FFT core
core_in_real  out  128  frame real, sample k at [16k+15:16k]
core_in_imag  out  128  frame imag, same packing
core_out_real  in  128  core result real, same packing
core_out_imag  in  128  core result imag, same packing
core_done  in  1  core result valid (level)
m_valid  out  1  output sample valid
m_ready  in  1  downstream accept
m_real  out  16  output sample real
m_imag  out  16  output sample imag
m_last  out  1  high on 8th sample of frame
m_id  out  ID_W  requester that owns the frame
busy  out  1  state != IDLE
err_timeout  out  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, s_ready=0, core_start=0, m_valid=0, m_last=0, m_id=0, busy=0, err_timeout=0, core_in_*=0, rr pointer=NUM_REQ-1, counters=0.
- Reset mid-operation aborts any frame immediately. No partial output follows.
- States: IDLE -> LOAD -> START -> WAIT -> UNLOAD -> IDLE.
- IDLE: if any s_valid, grant the first requester with s_valid searching from rr+1 modulo NUM_REQ. Latch grant, go to LOAD next cycle.
- LOAD: s_ready[grant]=1 (registered-free, combinational from state/grant); all other s_ready=0.
- LOAD handshake: each s_valid&s_ready transfer writes sample[cnt], cnt++. Transfer at cnt==7 goes to START.
- LOAD: the grant is not revoked if the requester drops s_valid; the scheduler waits.
- START: core_start=1 for exactly one cycle. core_in_* are held stable from START until leaving WAIT. Set rr=grant. Go to WAIT; watchdog=0.
- WAIT: on first cycle core_done=1, capture core_out_* into the output buffer and go to UNLOAD.
- WAIT timeout: if watchdog reaches TIMEOUT_CYCLES-1 without done, set err_timeout, discard the frame and go to IDLE.
- core_done outside WAIT is ignored.
- UNLOAD: m_valid=1, m_id=grant, m_real/m_imag=outbuf[ocnt]. ocnt advances on m_valid&m_ready. m_last=(ocnt==7). Transfer with m_last goes to IDLE.
- m_* are stable while m_valid & !m_ready.
- Minimum frame period: 8 (LOAD) + 1 (START) + core latency + 8 (UNLOAD) + 1 (IDLE) cycles.
- The core does not start the next frame before the current frame is fully unloaded. No overlap.
- No arithmetic on data; samples pass unmodified.

Optional Feature:
FFT_SCHED_PERF_EN
- Defined: adds output perf_frames (32 bits, completed frames, wraps at 2^32) and output perf_busy (32 bits, cycles with busy=1, wraps). Both reset to 0.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

Decomposition:
- Package fft8_sched_pkg: state enum (IDLE, LOAD, START, WAIT, UNLOAD), FRAME_LEN=8, SAMPLE_W=16, round-robin next-index function.
- One sub-module rr_arbiter: NUM_REQ request vector plus last-grant in, one-hot/index grant out, combinational.

Test Plan:
1. Reset, requester 0 sends samples 0x0001..0x0008 (imag 0), core model asserts done 5 cycles after start -> one core_start pulse; m_id=0; 8 outputs equal model values; m_last only on 8th; busy returns 0.
2. Both requesters continuously valid for 4 frames -> grants alternate 0,1,0,1; s_ready never high for two requesters at once.
3. m_ready toggles 1-0-0-1 during UNLOAD -> no sample lost or duplicated; m_* held while stalled.
4. Core model never asserts done -> err_timeout=1 after exactly TIMEOUT_CYCLES in WAIT; m_valid stays 0; next frame from requester 1 is processed normally with err_timeout still 1.
5. rst_n low at LOAD sample 4 -> all outputs at reset values next cycle; the following frame restarts at sample 0.
6. With FFT_SCHED_PERF_EN, 3 frames complete -> perf_frames=3; perf_busy equals the bench-counted busy cycles.
